// File: rtl/pc_pkg.sv
// Shared types and default vectors for the PC sequencer and its return-address stack.
// Purely declarative: no logic, no latency, no flow control.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        SEQ,
        TRAP,
        JUMP,
        JR,
        BRANCH
    } redir_cause_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the core control path (master) and the PC sequencer (slave).
// Requests are sampled on the next edge; there is no handshake, dropped requests must be re-held.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int JIDX_W = 26
);
    logic              stall;
    logic              halt;
    logic              resume;
    logic              trap;
    logic              jump;
    logic [JIDX_W-1:0] jump_idx;
    logic              jr;
    logic [ADDR_W-1:0] jr_target;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_off;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next_seq;
    logic              pc_valid;
    logic              redirect;
    logic              ras_underflow;

    modport master (
        output stall, halt, resume, trap, jump, jump_idx, jr, jr_target,
               branch_taken, branch_off, call, ret,
        input  pc, pc_next_seq, pc_valid, redirect, ras_underflow
    );

    modport slave (
        input  stall, halt, resume, trap, jump, jump_idx, jr, jr_target,
               branch_taken, branch_off, call, ret,
        output pc, pc_next_seq, pc_valid, redirect, ras_underflow
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; push when full overwrites the oldest entry.
// top/empty/full are combinational from state; push and pop take effect on the next edge.
module pc_ras #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_dat,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop_eff;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign top     = mem[top_ptr];
    assign pop_eff = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push && !pop_eff) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (pop_eff && !push) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

    // Pop+push replaces the top in place, leaving depth unchanged.
    always_ff @(posedge clk) begin
        if (push) begin
            if (pop_eff)
                mem[top_ptr] <= push_dat;
            else
                mem[top_ptr + PTR_W'(1)] <= push_dat;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-fetch-address sequencer with BOOT/RUN/HALT control; optional RAS under PC_RAS_EN.
// One clk from request to pc update; stalled jump/jr/branch requests are dropped, not queued.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                JIDX_W    = 26,
    parameter int                JSHIFT    = 2,
    parameter int                BR_SHIFT  = 2,
    parameter int                INC       = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
    parameter int                RAS_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam logic [ADDR_W-1:0] JMASK =
        {{(ADDR_W-JIDX_W-JSHIFT){1'b1}}, {(JIDX_W+JSHIFT){1'b0}}};

    pc_state_e         state;
    redir_cause_e      cause;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] jr_pc;
    logic              accept;
    logic              take_jump;
    logic              take_jr;
    logic              underflow_nxt;

    assign seq_pc    = pc_q + ADDR_W'(INC);
    assign jump_pc   = (pc_q & JMASK) | ({{(ADDR_W-JIDX_W){1'b0}}, bus.jump_idx} << JSHIFT);
    assign branch_pc = pc_q + (bus.branch_off << BR_SHIFT);
    assign accept    = (state == RUN) && !bus.trap && !bus.halt && !bus.stall;
    assign take_jump = accept && bus.jump;
    assign take_jr   = accept && !bus.jump && bus.jr;

`ifdef PC_RAS_EN
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              unused_ras_full;

    assign ras_push = (take_jump || take_jr) && bus.call;
    assign ras_pop  = take_jr && bus.ret;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_dat (seq_pc),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (unused_ras_full)
    );

    assign jr_pc         = (bus.ret && !ras_empty) ? ras_top : bus.jr_target;
    assign underflow_nxt = ras_pop && ras_empty;
`else
    logic unused_ras_req;

    assign unused_ras_req = &{1'b0, bus.call, bus.ret};
    assign jr_pc          = bus.jr_target;
    assign underflow_nxt  = 1'b0;
`endif

    always_comb begin
        cause  = SEQ;
        pc_nxt = seq_pc;
        if (bus.trap) begin
            cause  = TRAP;
            pc_nxt = TRAP_VEC;
        end else if (take_jump) begin
            cause  = JUMP;
            pc_nxt = jump_pc;
        end else if (take_jr) begin
            cause  = JR;
            pc_nxt = jr_pc;
        end else if (accept && bus.branch_taken) begin
            cause  = BRANCH;
            pc_nxt = branch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= BOOT;
            pc_q              <= RESET_VEC;
            bus.pc_valid      <= 1'b0;
            bus.redirect      <= 1'b0;
            bus.ras_underflow <= 1'b0;
        end else begin
            bus.redirect      <= 1'b0;
            bus.ras_underflow <= 1'b0;
            case (state)
                BOOT: begin
                    state        <= RUN;
                    bus.pc_valid <= 1'b1;
                end
                RUN: begin
                    if (bus.trap) begin
                        pc_q         <= pc_nxt;
                        bus.redirect <= 1'b1;
                    end else if (bus.halt) begin
                        state        <= HALT;
                        bus.pc_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        pc_q              <= pc_nxt;
                        bus.redirect      <= (cause != SEQ);
                        bus.ras_underflow <= underflow_nxt;
                    end
                end
                HALT: begin
                    if (bus.trap) begin
                        state        <= RUN;
                        pc_q         <= TRAP_VEC;
                        bus.pc_valid <= 1'b1;
                        bus.redirect <= 1'b1;
                    end else if (bus.resume) begin
                        state        <= RUN;
                        bus.pc_valid <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_next_seq = seq_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer (default parameters): directed scenarios plus random traffic against a queue-based model.
// RAS scenarios follow PC_RAS_EN exactly as the design build does.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(32), .JIDX_W(26)) bus ();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    localparam int RAS_D = 4;

    // Reference model: mode 0=booting, 1=running, 2=halted.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_red;
    logic        m_uf;
    int          m_mode;
    logic [31:0] m_ras [$];

    task automatic clear_inputs();
        bus.stall = 0; bus.halt = 0; bus.resume = 0; bus.trap = 0;
        bus.jump = 0; bus.jump_idx = '0; bus.jr = 0; bus.jr_target = '0;
        bus.branch_taken = 0; bus.branch_off = '0; bus.call = 0; bus.ret = 0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 0; m_red = 0; m_uf = 0; m_mode = 0;
        m_ras.delete();
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        m_red = 0;
        m_uf  = 0;
        if (m_mode == 0) begin
            m_mode = 1; m_valid = 1;
        end else if (m_mode == 2) begin
            if (bus.trap) begin
                m_pc = 32'h80; m_mode = 1; m_valid = 1; m_red = 1;
            end else if (bus.resume) begin
                m_mode = 1; m_valid = 1;
            end
        end else if (bus.trap) begin
            m_pc = 32'h80; m_red = 1;
        end else if (bus.halt) begin
            m_mode = 2; m_valid = 0;
        end else if (bus.stall) begin
            m_red = 0;
        end else if (bus.jump || bus.jr) begin
            if (bus.jump) begin
                tgt = {m_pc[31:28], bus.jump_idx, 2'b00};
            end else begin
                tgt = bus.jr_target;
`ifdef PC_RAS_EN
                if (bus.ret) begin
                    if (m_ras.size() > 0) tgt = m_ras.pop_back();
                    else m_uf = 1;
                end
`endif
            end
`ifdef PC_RAS_EN
            if (bus.call) begin
                m_ras.push_back(m_pc + 32'd1);
                if (m_ras.size() > RAS_D) void'(m_ras.pop_front());
            end
`endif
            m_pc  = tgt;
            m_red = 1;
        end else if (bus.branch_taken) begin
            m_pc  = m_pc + bus.branch_off * 32'd4;
            m_red = 1;
        end else begin
            m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        clear_inputs();
    endtask

    task automatic goto_pc(input logic [31:0] a);
        bus.jr = 1; bus.jr_target = a;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        model_reset();
        #3;
        n_checks++; if (bus.pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", bus.pc); else n_pass++;
        n_checks++; if (bus.pc_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.pc_valid); else n_pass++;
        n_checks++; if (bus.redirect !== 1'b0) $display("FAIL reset_redirect got=%b exp=0", bus.redirect); else n_pass++;
        n_checks++; if (bus.ras_underflow !== 1'b0) $display("FAIL reset_uf got=%b exp=0", bus.ras_underflow); else n_pass++;
        @(negedge clk) rst = 0;
        tick();
        n_checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 32'h0) $display("FAIL boot_run valid=%b pc=%h exp 1/0", bus.pc_valid, bus.pc); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h1) $display("FAIL seq1 got=%h exp=1", bus.pc); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h2 || bus.redirect !== 1'b0) $display("FAIL seq2 pc=%h red=%b exp 2/0", bus.pc, bus.redirect); else n_pass++;
        n_checks++; if (bus.pc_next_seq !== 32'h3) $display("FAIL next_seq got=%h exp=3", bus.pc_next_seq); else n_pass++;
    endtask

    task automatic test_branch();
        goto_pc(32'h10);
        n_checks++; if (bus.pc !== 32'h10 || bus.redirect !== 1'b1) $display("FAIL jr_10 pc=%h red=%b exp 10/1", bus.pc, bus.redirect); else n_pass++;
        bus.branch_taken = 1; bus.branch_off = 32'hFFFF_FFFF;
        tick();
        n_checks++; if (bus.pc !== 32'h0C || bus.redirect !== 1'b1) $display("FAIL branch_back pc=%h red=%b exp c/1", bus.pc, bus.redirect); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'h0D || bus.redirect !== 1'b0) $display("FAIL after_branch pc=%h red=%b exp d/0", bus.pc, bus.redirect); else n_pass++;
        goto_pc(32'hFFFF_FFFF);
        tick();
        n_checks++; if (bus.pc !== 32'h0) $display("FAIL wrap got=%h exp=0", bus.pc); else n_pass++;
    endtask

    task automatic test_stall();
        goto_pc(32'h30);
        bus.jump = 1; bus.jump_idx = 26'h5; bus.branch_taken = 1; bus.branch_off = 32'h3; bus.stall = 1;
        tick();
        n_checks++; if (bus.pc !== 32'h30 || bus.redirect !== 1'b0) $display("FAIL stall_hold pc=%h red=%b exp 30/0", bus.pc, bus.redirect); else n_pass++;
        bus.trap = 1; bus.stall = 1;
        tick();
        n_checks++; if (bus.pc !== 32'h80 || bus.redirect !== 1'b1) $display("FAIL trap_stall pc=%h red=%b exp 80/1", bus.pc, bus.redirect); else n_pass++;
    endtask

    task automatic test_jump();
        goto_pc(32'hF000_0000);
        bus.jump = 1; bus.jump_idx = 26'h10;
        tick();
        n_checks++; if (bus.pc !== 32'hF000_0040 || bus.redirect !== 1'b1) $display("FAIL jump pc=%h red=%b exp f0000040/1", bus.pc, bus.redirect); else n_pass++;
    endtask

    task automatic test_halt();
        bus.halt = 1;
        tick();
        n_checks++; if (bus.pc_valid !== 1'b0 || bus.pc !== 32'hF000_0040) $display("FAIL halt_enter valid=%b pc=%h exp 0/f0000040", bus.pc_valid, bus.pc); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            bus.jump = 1; bus.jump_idx = 26'h77; bus.branch_taken = 1; bus.branch_off = 32'h9;
            tick();
            n_checks++; if (bus.pc !== 32'hF000_0040 || bus.pc_valid !== 1'b0 || bus.redirect !== 1'b0)
                $display("FAIL halt_frozen pc=%h valid=%b red=%b exp f0000040/0/0", bus.pc, bus.pc_valid, bus.redirect); else n_pass++;
        end
        bus.resume = 1;
        tick();
        n_checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 32'hF000_0040 || bus.redirect !== 1'b0)
            $display("FAIL resume valid=%b pc=%h red=%b exp 1/f0000040/0", bus.pc_valid, bus.pc, bus.redirect); else n_pass++;
        tick();
        n_checks++; if (bus.pc !== 32'hF000_0041) $display("FAIL post_resume got=%h exp=f0000041", bus.pc); else n_pass++;
        bus.halt = 1;
        tick();
        bus.trap = 1;
        tick();
        n_checks++; if (bus.pc !== 32'h80 || bus.pc_valid !== 1'b1 || bus.redirect !== 1'b1)
            $display("FAIL trap_exit pc=%h valid=%b red=%b exp 80/1/1", bus.pc, bus.pc_valid, bus.redirect); else n_pass++;
    endtask

    task automatic test_mid_reset();
        goto_pc(32'h40);
        n_checks++; if (bus.pc !== 32'h40) $display("FAIL pre_rst got=%h exp=40", bus.pc); else n_pass++;
        #2 rst = 1;
        #1;
        n_checks++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0 || bus.redirect !== 1'b0)
            $display("FAIL async_rst pc=%h valid=%b red=%b exp 0/0/0", bus.pc, bus.pc_valid, bus.redirect); else n_pass++;
        model_reset();
        @(negedge clk) rst = 0;
        tick();
        n_checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 32'h0) $display("FAIL rst_boot valid=%b pc=%h exp 1/0", bus.pc_valid, bus.pc); else n_pass++;
        tick();
        tick();
        n_checks++; if (bus.pc !== 32'h2) $display("FAIL rst_seq got=%h exp=2", bus.pc); else n_pass++;
    endtask

    task automatic test_ras();
`ifdef PC_RAS_EN
        logic [31:0] exp_t [5];
        exp_t = '{32'h6, 32'h5, 32'h4, 32'h3, 32'h99};
        goto_pc(32'h1);
        for (int i = 1; i <= 5; i++) begin
            bus.jr = 1; bus.call = 1; bus.jr_target = 32'(i + 1);
            tick();
        end
        n_checks++; if (bus.pc !== 32'h6) $display("FAIL ras_calls got=%h exp=6", bus.pc); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            bus.jr = 1; bus.ret = 1; bus.jr_target = 32'h99;
            tick();
            n_checks++; if (bus.pc !== exp_t[k]) $display("FAIL ras_ret%0d got=%h exp=%h", k, bus.pc, exp_t[k]); else n_pass++;
            n_checks++; if (bus.ras_underflow !== (k == 4)) $display("FAIL ras_uf%0d got=%b exp=%b", k, bus.ras_underflow, (k == 4)); else n_pass++;
        end
        tick();
        n_checks++; if (bus.ras_underflow !== 1'b0) $display("FAIL ras_uf_pulse got=%b exp=0", bus.ras_underflow); else n_pass++;
`else
        goto_pc(32'h10);
        bus.jr = 1; bus.ret = 1; bus.call = 1; bus.jr_target = 32'h99;
        tick();
        n_checks++; if (bus.pc !== 32'h99) $display("FAIL plain_ret got=%h exp=99", bus.pc); else n_pass++;
        n_checks++; if (bus.ras_underflow !== 1'b0) $display("FAIL no_ras_uf got=%b exp=0", bus.ras_underflow); else n_pass++;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.stall        = ($urandom_range(0, 4) == 0);
            bus.halt         = ($urandom_range(0, 22) == 0);
            bus.resume       = ($urandom_range(0, 2) == 0);
            bus.trap         = ($urandom_range(0, 28) == 0);
            bus.jump         = ($urandom_range(0, 5) == 0);
            bus.jr           = ($urandom_range(0, 4) == 0);
            bus.branch_taken = ($urandom_range(0, 3) == 0);
            bus.call         = ($urandom_range(0, 2) == 0);
            bus.ret          = ($urandom_range(0, 2) == 0);
            bus.jump_idx     = 26'($urandom);
            bus.jr_target    = $urandom;
            bus.branch_off   = 32'($urandom_range(0, 63)) - 32'd32;
            tick();
            n_checks++; if (bus.pc !== m_pc) $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, bus.pc, m_pc); else n_pass++;
            n_checks++; if (bus.pc_valid !== m_valid) $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.pc_valid, m_valid); else n_pass++;
            n_checks++; if (bus.redirect !== m_red) $display("FAIL rnd_redirect[%0d] got=%b exp=%b", i, bus.redirect, m_red); else n_pass++;
            n_checks++; if (bus.ras_underflow !== m_uf) $display("FAIL rnd_uf[%0d] got=%b exp=%b", i, bus.ras_underflow, m_uf); else n_pass++;
            n_checks++; if (bus.pc_next_seq !== m_pc + 32'd1) $display("FAIL rnd_next_seq[%0d] got=%h exp=%h", i, bus.pc_next_seq, m_pc + 32'd1); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall();
        test_jump();
        test_halt();
        test_mid_reset();
        test_ras();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
